// File: rtl/semi_pixel_serializer.sv
// Semigraphics scanline serializer: takes pre-decoded pattern/colour bytes over a
// valid/ready handshake, shifts them out one pixel per PixEn, and owns the cell row counter.
module semi_pixel_serializer #(
  parameter int BYTES_PER_LINE = 32,
  parameter int ROWS_PER_CELL  = 12
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       PixEn,
  input  logic       LineStart,
  input  logic       FieldStart,
  input  logic [7:0] SData,
  input  logic [3:0] SColour,
  input  logic       DataValid,
  output logic       DataReady,
  output logic [3:0] Row,
  output logic [3:0] PixColour,
  output logic       PixActive,
  output logic       LineDone,
  output logic       Underrun
);

  localparam logic [7:0] BPL      = 8'(BYTES_PER_LINE);
  localparam logic [3:0] ROW_LAST = 4'(ROWS_PER_CELL - 1);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] colour_q, colour_d;
  logic [7:0] hold_pat_q, hold_pat_d;
  logic [3:0] hold_col_q, hold_col_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0] shown_cnt_q, shown_cnt_d;
  logic [3:0] row_q, row_d;
  logic       line_done_q, line_done_d;
  logic       underrun_q, underrun_d;
  logic       ready;
  logic       xfer;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      colour_q    <= '0;
      hold_pat_q  <= '0;
      hold_col_q  <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      fetch_cnt_q <= '0;
      shown_cnt_q <= '0;
      row_q       <= '0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      colour_q    <= colour_d;
      hold_pat_q  <= hold_pat_d;
      hold_col_q  <= hold_col_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      shown_cnt_q <= shown_cnt_d;
      row_q       <= row_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    colour_d    = colour_q;
    hold_pat_d  = hold_pat_q;
    hold_col_d  = hold_col_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    shown_cnt_d = shown_cnt_q;
    row_d       = row_q;
    line_done_d = 1'b0;
    underrun_d  = underrun_q;

    ready = (state_q == FILL) ||
            ((state_q == ACTIVE) && !hold_full_q && (fetch_cnt_q < BPL));
    xfer  = DataValid && ready;

    unique case (state_q)
      FILL: begin
        // First byte of the line bypasses the holding register
        if (xfer) begin
          shift_d     = SData;
          colour_d    = SColour;
          fetch_cnt_d = 8'd1;
          shown_cnt_d = 8'd1;
          bit_cnt_d   = 3'd0;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          hold_pat_d  = SData;
          hold_col_d  = SColour;
          hold_full_d = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 8'd1;
        end
        if (PixEn) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shown_cnt_q == BPL) begin
              state_d     = IDLE;
              line_done_d = 1'b1;
              row_d       = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
            end else begin
              // A late byte landing on this same edge still fills holding for the next slot
              if (hold_full_q) begin
                shift_d     = hold_pat_q;
                colour_d    = hold_col_q;
                hold_full_d = xfer;
              end else begin
                shift_d    = 8'h00;
                colour_d   = 4'd0;
                underrun_d = 1'b1;
              end
              shown_cnt_d = shown_cnt_q + 8'd1;
            end
          end
        end
      end
      default: ;
    endcase

    if (FieldStart) begin
      row_d = 4'd0;
      if (!LineStart) state_d = IDLE;
    end

    // LineStart aborts any line in progress without touching the row
    if (LineStart) begin
      state_d     = FILL;
      fetch_cnt_d = 8'd0;
      shown_cnt_d = 8'd0;
      bit_cnt_d   = 3'd0;
      hold_full_d = 1'b0;
      underrun_d  = 1'b0;
      line_done_d = 1'b0;
      row_d       = FieldStart ? 4'd0 : row_q;
    end
  end

  assign DataReady = ready;
  assign PixActive = (state_q == ACTIVE);
  assign PixColour = (PixActive && shift_q[7]) ? colour_q : 4'd0;
  assign Row       = row_q;
  assign LineDone  = line_done_q;
  assign Underrun  = underrun_q;

endmodule

// File: tb/tb_semi_pixel_serializer.sv
// Scoreboard bench for semi_pixel_serializer: a line-level reference model queues expected
// pixels per byte slot; a negedge monitor pops and compares each displayed pixel.
module tb_semi_pixel_serializer;

  localparam int BPL = 32;
  localparam int RPC = 12;
  localparam int S_IDLE = 0;
  localparam int S_FILL = 1;
  localparam int S_ACT  = 2;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       PixEn = 1'b0;
  logic       LineStart = 1'b0;
  logic       FieldStart = 1'b0;
  logic       DataValid = 1'b0;
  logic [7:0] SData = 8'h00;
  logic [3:0] SColour = 4'h0;
  logic       DataReady, PixActive, LineDone, Underrun;
  logic [3:0] Row, PixColour;

  semi_pixel_serializer #(.BYTES_PER_LINE(BPL), .ROWS_PER_CELL(RPC)) dut (
    .Clk(Clk), .nReset(nReset), .PixEn(PixEn), .LineStart(LineStart),
    .FieldStart(FieldStart), .SData(SData), .SColour(SColour), .DataValid(DataValid),
    .DataReady(DataReady), .Row(Row), .PixColour(PixColour), .PixActive(PixActive),
    .LineDone(LineDone), .Underrun(Underrun)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: line state, pixels consumed, bytes accepted, pending (held) bytes
  int          m_state = S_IDLE;
  int          m_pix = 0;
  int          m_fetched = 0;
  int          m_row = 0;
  bit          m_und = 1'b0;
  bit          m_ld = 1'b0;
  bit          m_took = 1'b0;
  logic [11:0] m_pend[$];
  logic [3:0]  exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_ready();
    if (m_state == S_FILL) return 1'b1;
    if (m_state == S_ACT) return (m_pend.size() == 0) && (m_fetched < BPL);
    return 1'b0;
  endfunction

  task automatic push_slot(input logic [7:0] p, input logic [3:0] c);
    for (int b = 7; b >= 0; b--) exp_q.push_back(p[b] ? c : 4'd0);
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_pix = 0; m_fetched = 0; m_row = 0;
    m_und = 1'b0; m_ld = 1'b0; m_took = 1'b0;
    m_pend.delete(); exp_q.delete();
  endtask

  task automatic model_edge();
    bit xfer;
    xfer   = DataValid && model_ready();
    m_took = 1'b0;
    m_ld   = 1'b0;
    if (LineStart) begin
      m_state = S_FILL; m_pix = 0; m_fetched = 0; m_und = 1'b0;
      m_pend.delete(); exp_q.delete();
    end else if (m_state == S_FILL) begin
      if (xfer) begin
        push_slot(SData, SColour);
        m_fetched = 1; m_pix = 0; m_state = S_ACT; m_took = 1'b1;
      end
    end else if (m_state == S_ACT) begin
      if (PixEn) begin
        m_pix++;
        if (m_pix == 8 * BPL) begin
          m_state = S_IDLE; m_ld = 1'b1; m_row = (m_row + 1) % RPC;
        end else if (m_pix % 8 == 0) begin
          if (m_pend.size() > 0) begin
            push_slot(m_pend[0][7:0], m_pend[0][11:8]);
            void'(m_pend.pop_front());
          end else begin
            push_slot(8'h00, 4'd0);
            m_und = 1'b1;
          end
        end
      end
      if (xfer) begin
        m_pend.push_back({SColour, SData});
        m_fetched++;
        m_took = 1'b1;
      end
    end
    if (FieldStart) begin
      m_row = 0;
      if (!LineStart) begin m_state = S_IDLE; exp_q.delete(); end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    if (nReset) model_edge();
    #1;
    if (nReset) begin
      chk("DataReady", DataReady, model_ready());
      chk("LineDone", LineDone, m_ld);
      chk("Underrun", Underrun, m_und);
      chk("Row", Row, m_row);
    end
  endtask

  always @(negedge Clk) begin
    if (nReset) begin
      chk("PixActive", PixActive, m_state == S_ACT);
      if (m_state == S_ACT) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL pixel_queue: no expected pixel, got colour %0d at t=%0t", PixColour, $time);
        end else begin
          chk("PixColour", PixColour, exp_q[0]);
          if (PixEn) void'(exp_q.pop_front());
        end
      end else begin
        chk("PixColour_idle", PixColour, 0);
      end
    end
  end

  // mode: 0 random, 1 back-pressure/alternating, 2 underrun on byte 2,
  //       3 abort in 10th byte, 4 FieldStart on LineDone edge, 5 FieldStart with LineStart
  task automatic run_line(input int mode);
    logic [7:0] pat[BPL];
    logic [3:0] col[BPL];
    int nxt = 0;
    int dly;
    int cyc = 0;
    bit aborted = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < BPL; i++) begin
      if (mode == 1) begin
        pat[i] = (i % 2 == 1) ? 8'h0F : 8'hFF;
        col[i] = (i % 2 == 1) ? 4'd8 : 4'd5;
      end else begin
        pat[i] = 8'($urandom_range(0, 255));
        col[i] = 4'($urandom_range(1, 15));
      end
    end
    PixEn = 1'b0; DataValid = 1'b0;
    LineStart = 1'b1; FieldStart = (mode == 5);
    step();
    LineStart = 1'b0; FieldStart = 1'b0;
    dly = (mode == 0) ? $urandom_range(0, 2) : 2;
    while (!done) begin
      if (m_took) begin
        nxt++;
        DataValid = 1'b0;
        dly = (mode == 0) ? $urandom_range(0, 2) : 2;
      end
      if (mode == 2 && nxt == 2 && m_und) nxt++;
      if (!DataValid && nxt < BPL && model_ready() && !(mode == 2 && nxt == 2)) begin
        if (dly > 0) dly--;
        else begin
          DataValid = 1'b1; SData = pat[nxt]; SColour = col[nxt];
        end
      end
      PixEn = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      LineStart = 1'b0; FieldStart = 1'b0;
      if (mode == 3 && !aborted && m_state == S_ACT && m_pix / 8 == 9) begin
        LineStart = 1'b1; aborted = 1'b1; nxt = 0; DataValid = 1'b0; dly = 2;
      end
      if (mode == 4 && m_state == S_ACT && PixEn && m_pix == 8 * BPL - 1) FieldStart = 1'b1;
      step();
      if (LineStart) chk("abort_ready_next", DataReady, 1);
      done = m_ld;
      cyc++;
      if (cyc > 5000) begin
        vectors++; errors++;
        $display("FAIL line_timeout: no LineDone after %0d cycles, mode %0d", cyc, mode);
        done = 1'b1;
      end
    end
    DataValid = 1'b0; PixEn = 1'b0; LineStart = 1'b0; FieldStart = 1'b0;
    chk("underrun_at_end", Underrun, mode == 2);
    if (mode == 4) chk("row_after_fieldstart", Row, 0);
    repeat ($urandom_range(1, 3)) step();
  endtask

  initial begin
    int row_before;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_DataReady", DataReady, 0);
    chk("rst_PixActive", PixActive, 0);
    chk("rst_PixColour", PixColour, 0);
    chk("rst_LineDone", LineDone, 0);
    chk("rst_Underrun", Underrun, 0);
    chk("rst_Row", Row, 0);
    model_reset();
    @(negedge Clk) nReset = 1'b1;
    step(); step();

    run_line(1);
    run_line(0);
    run_line(0);
    run_line(2);
    row_before = Row;
    run_line(3);
    chk("abort_row_single_step", Row, (row_before + 1) % RPC);

    run_line(5);
    chk("row_after_field_line", Row, 1);
    for (int i = 0; i < 3; i++) run_line(0);
    chk("row_before_line5", Row, 4);
    run_line(4);
    for (int i = 0; i < RPC; i++) begin
      run_line(1);
      chk("row_wrap_step", Row, (i + 1) % RPC);
    end

    // Asynchronous reset in the middle of a line
    LineStart = 1'b1; step(); LineStart = 1'b0;
    DataValid = 1'b1; SData = 8'hA5; SColour = 4'd7; PixEn = 1'b1;
    repeat (20) step();
    #3;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_DataReady", DataReady, 0);
    chk("async_rst_PixActive", PixActive, 0);
    chk("async_rst_PixColour", PixColour, 0);
    chk("async_rst_LineDone", LineDone, 0);
    chk("async_rst_Underrun", Underrun, 0);
    chk("async_rst_Row", Row, 0);
    DataValid = 1'b0; PixEn = 1'b0;
    @(negedge Clk) nReset = 1'b1;
    step();
    chk("post_rst_idle_ready", DataReady, 0);
    chk("post_rst_idle_active", PixActive, 0);
    run_line(0);
    chk("row_after_post_rst_line", Row, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
